decimal_entry_to_bin: RTL

- Sequential decimal-entry front end: the user keys in up to 3 decimal digits on SW[3:0], each strobed by a key press, then presses enter.
- The accumulated number is converted to binary and presented on LEDR. This is the inverse path of the binary-to-3-digit-display block.
- Digits entered so far are echoed on HEX2..HEX0 using the team's standard active-low 7-segment encoding.
- The block sits between the board switches/keys and any logic that consumes a 7-bit operand.

---
 rtl/decimal_entry_to_bin.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/decimal_entry_to_bin.sv
// Decimal keypad entry (up to three digits) converted to a binary operand,
// with an active-low 7-segment echo of the digits typed so far.
module decimal_entry_to_bin #(
    parameter int VAL_W     = 7,
    parameter int MAX_VALUE = 127
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [3:0]       SW,
    input  logic             digit_key,
    input  logic             enter_key,
    input  logic             clear,
    output logic [VAL_W-1:0] LEDR,
    output logic             value_valid,
    output logic             error,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [9:0] MAX_ACC   = 10'(MAX_VALUE);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [9:0]       acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0]       d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic             dk_q, ek_q;
    logic [VAL_W-1:0] ledr_q, ledr_d;
    logic             vv_q, vv_d, err_q, err_d;
    logic [6:0]       hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
    logic             dig_ev, ent_ev;

    assign dig_ev = digit_key & ~dk_q;
    assign ent_ev = enter_key & ~ek_q;

    // State register; the key-edge flops survive a soft clear.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 10'd0;
            cnt_q   <= 2'd0;
            d0_q    <= 4'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            dk_q    <= 1'b0;
            ek_q    <= 1'b0;
            ledr_q  <= '0;
            vv_q    <= 1'b0;
            err_q   <= 1'b0;
            hex0_q  <= SEG_BLANK;
            hex1_q  <= SEG_BLANK;
            hex2_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            dk_q    <= digit_key;
            ek_q    <= enter_key;
            ledr_q  <= ledr_d;
            vv_q    <= vv_d;
            err_q   <= err_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
        end
    end

    // Next-state and datapath; a digit event shadows a simultaneous enter.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        ledr_d  = ledr_q;
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = 10'd0;
            cnt_d   = 2'd0;
            ledr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (dig_ev) begin
                        if (SW <= 4'd9) begin
                            state_d = S_ENTRY;
                            acc_d   = {6'd0, SW};
                            cnt_d   = 2'd1;
                            d0_d    = SW;
                            d1_d    = 4'd0;
                            d2_d    = 4'd0;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ENTRY: begin
                    if (dig_ev) begin
                        if ((SW <= 4'd9) && (cnt_q < 2'd3)) begin
                            acc_d = (acc_q * 10'd10) + {6'd0, SW};
                            cnt_d = cnt_q + 2'd1;
                            d2_d  = d1_q;
                            d1_d  = d0_q;
                            d0_d  = SW;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end else if (ent_ev) begin
                        if (acc_q <= MAX_ACC) begin
                            state_d = S_DONE;
                            ledr_d  = acc_q[VAL_W-1:0];
                        end else begin
                            state_d = S_ERROR;
                        end
                    end else begin
                        state_d = S_ENTRY;
                    end
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered outputs derived from the upcoming state.
    always_comb begin
        vv_d   = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
        hex0_d = SEG_BLANK;
        hex1_d = SEG_BLANK;
        hex2_d = SEG_BLANK;
        if (state_d == S_ERROR) begin
            hex0_d = SEG_E;
        end else begin
            hex0_d = (cnt_d > 2'd0) ? seg7(d0_d) : SEG_BLANK;
            hex1_d = (cnt_d > 2'd1) ? seg7(d1_d) : SEG_BLANK;
            hex2_d = (cnt_d > 2'd2) ? seg7(d2_d) : SEG_BLANK;
        end
    end

    assign LEDR        = ledr_q;
    assign value_valid = vv_q;
    assign error       = err_q;
    assign HEX0        = hex0_q;
    assign HEX1        = hex1_q;
    assign HEX2        = hex2_q;

endmodule
